rob_unit: RTL and testbench

- Reorder buffer: circular queue of in-flight instructions, in program order.
- Allocates entries at issue and captures results from the common data bus (CDB).
- Answers operand lookups by ROB tag for the register-rename stage and retires the head entry in order.
- Sits between issue/CDB and the architectural register file; commit outputs feed the register file's commit port.

---
 rtl/rob_unit_pkg.sv | 30 +++
 rtl/rob_unit.sv | 160 ++++++++++++++++
 tb/tb_rob_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_unit_pkg.sv
// Shared types and constants for the reorder buffer.
// ROB_DEPTH must be a power of two and ROB_W must equal log2(ROB_DEPTH),
// so that pointer arithmetic wraps for free.
package rob_unit_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_W     = 4;
  localparam int REG_W     = 5;
  localparam int XLEN      = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [ROB_W-1:0] rob_id_t;   // ROB tag
  typedef logic [REG_W-1:0] reg_id_t;   // architectural register index
  typedef logic [XLEN-1:0]  word_t;     // data word
  typedef logic [ROB_W:0]   rob_cnt_t;  // occupancy, 0..ROB_DEPTH inclusive

  // Result of an operand lookup by tag.
  typedef struct packed {
    logic  rdy;
    word_t val;
  } lookup_t;

  // Advance a circular pointer; wraps because ROB_DEPTH is a power of two.
  function automatic rob_id_t rob_next(input rob_id_t p);
    return p + rob_id_t'(1);
  endfunction

endpackage

// File: rtl/rob_unit.sv
// Reorder buffer: circular queue of in-flight instructions in program order.
// Allocates at the tail on issue, captures results from the CDB, answers
// operand lookups by tag and retires the head entry in order into the
// architectural register file's commit port.
// Optional feature: define ROB_CDB_BYPASS_EN to forward a same-cycle CDB
// broadcast straight to the lookup ports.
module rob_unit
  import rob_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             IS_sgn,
  input  logic [REG_W-1:0] IS_rd,
  output logic             IS_full,
  output logic [ROB_W-1:0] ROB_name,
  input  logic             CDB_sgn,
  input  logic [ROB_W-1:0] CDB_name,
  input  logic [XLEN-1:0]  CDB_val,
  input  logic [ROB_W-1:0] ROB_ord1,
  input  logic [ROB_W-1:0] ROB_ord2,
  output logic             ROB_rdy1,
  output logic             ROB_rdy2,
  output logic [XLEN-1:0]  ROB_val1,
  output logic [XLEN-1:0]  ROB_val2,
  output logic             ROB_commit_sgn,
  output logic [REG_W-1:0] ROB_commit_dest,
  output logic [XLEN-1:0]  ROB_commit_value,
  output logic [ROB_W-1:0] ROB_commit_ROB_name
);

  // Per-entry control bits live in vectors (reset), payload in arrays (no reset).
  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] ready_q;
  reg_id_t              rd_q  [ROB_DEPTH];
  word_t                val_q [ROB_DEPTH];

  rob_id_t  head_q;
  rob_id_t  tail_q;
  rob_cnt_t count_q;

  logic    do_alloc;
  logic    do_cdb;
  logic    do_retire;
  lookup_t look1;
  lookup_t look2;

  // Full is judged from the current count, so a commit that frees a slot
  // does not let an allocation through in the same cycle.
  assign IS_full  = (count_q == rob_cnt_t'(ROB_DEPTH));
  assign ROB_name = tail_q;

  // Qualified events for this cycle; clr overrides all of them.
  always_comb begin
    do_alloc  = rdy && !clr && IS_sgn && !IS_full;
    do_cdb    = rdy && !clr && CDB_sgn && busy_q[CDB_name];
    do_retire = rdy && !clr && busy_q[head_q] && ready_q[head_q];
  end

  // Control state: pointers, occupancy, entry flags and the commit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: all state in clocked blocks uses non-blocking (<=) so every
      // register samples pre-edge values regardless of statement order.
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      busy_q              <= '0;
      ready_q             <= '0;
      ROB_commit_sgn      <= FALSE;
      ROB_commit_dest     <= '0;
      ROB_commit_value    <= '0;
      ROB_commit_ROB_name <= '0;
    end else if (!rdy) begin
      // Stalled: everything holds, but a commit pulse never stretches.
      ROB_commit_sgn <= FALSE;
    end else if (clr) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      ROB_commit_sgn <= FALSE;
    end else begin
      // A retiring rd==0 entry frees its slot but raises no pulse.
      ROB_commit_sgn <= do_retire && (rd_q[head_q] != '0);

      if (do_cdb) begin
        ready_q[CDB_name] <= TRUE;
      end

      // Retire after the CDB update so a retiring head always ends up clear.
      if (do_retire) begin
        ROB_commit_dest     <= rd_q[head_q];
        ROB_commit_value    <= val_q[head_q];
        ROB_commit_ROB_name <= head_q;
        busy_q[head_q]      <= FALSE;
        ready_q[head_q]     <= FALSE;
        head_q              <= rob_next(head_q);
      end

      // The tail slot is never busy when allocation is allowed, so it cannot
      // collide with the CDB or retire updates above.
      if (do_alloc) begin
        busy_q[tail_q]  <= TRUE;
        ready_q[tail_q] <= FALSE;
        tail_q          <= rob_next(tail_q);
      end

      unique case ({do_alloc, do_retire})
        2'b10:   count_q <= count_q + rob_cnt_t'(1);
        2'b01:   count_q <= count_q - rob_cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload: destination at allocation, value from the CDB.
  // NOTE: payload arrays are deliberately not reset; busy/ready gate every
  // read, so stale contents are never observable and the RAM stays reset-free.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      rd_q[tail_q] <= IS_rd;
    end
    if (do_cdb) begin
      val_q[CDB_name] <= CDB_val;
    end
  end

  // Operand lookup for the rename stage; value reads as 0 unless ready.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    look1 = '0;
    look2 = '0;
    if (busy_q[ROB_ord1] && ready_q[ROB_ord1]) begin
      look1 = '{rdy: TRUE, val: val_q[ROB_ord1]};
    end
    if (busy_q[ROB_ord2] && ready_q[ROB_ord2]) begin
      look2 = '{rdy: TRUE, val: val_q[ROB_ord2]};
    end
`ifdef ROB_CDB_BYPASS_EN
    // Forward a live broadcast so the consumer does not wait a cycle.
    if (CDB_sgn && (CDB_name == ROB_ord1) && busy_q[ROB_ord1]) begin
      look1 = '{rdy: TRUE, val: CDB_val};
    end
    if (CDB_sgn && (CDB_name == ROB_ord2) && busy_q[ROB_ord2]) begin
      look2 = '{rdy: TRUE, val: CDB_val};
    end
`else
    // Stored state only: a result is visible the cycle after its broadcast.
`endif
  end

  assign ROB_rdy1 = look1.rdy;
  assign ROB_val1 = look1.val;
  assign ROB_rdy2 = look2.rdy;
  assign ROB_val2 = look2.val;

endmodule

// File: tb/tb_rob_unit.sv
// Self-checking bench for rob_unit: a table of directed vectors, hand-written
// multi-cycle corner sequences and a randomized run, all compared against a
// program-order queue model of the reorder buffer.
module tb_rob_unit;
  import rob_unit_pkg::*;

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rdy, clr, IS_sgn, IS_full, CDB_sgn;
  logic [4:0]       IS_rd;
  logic [3:0]       ROB_name, CDB_name, ROB_ord1, ROB_ord2;
  logic [31:0]      CDB_val, ROB_val1, ROB_val2;
  logic             ROB_rdy1, ROB_rdy2, ROB_commit_sgn;
  logic [4:0]       ROB_commit_dest;
  logic [31:0]      ROB_commit_value;
  logic [3:0]       ROB_commit_ROB_name;

  always #5 clk = ~clk;

  rob_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .IS_sgn(IS_sgn), .IS_rd(IS_rd), .IS_full(IS_full), .ROB_name(ROB_name),
    .CDB_sgn(CDB_sgn), .CDB_name(CDB_name), .CDB_val(CDB_val),
    .ROB_ord1(ROB_ord1), .ROB_ord2(ROB_ord2),
    .ROB_rdy1(ROB_rdy1), .ROB_rdy2(ROB_rdy2),
    .ROB_val1(ROB_val1), .ROB_val2(ROB_val2),
    .ROB_commit_sgn(ROB_commit_sgn), .ROB_commit_dest(ROB_commit_dest),
    .ROB_commit_value(ROB_commit_value), .ROB_commit_ROB_name(ROB_commit_ROB_name)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rdy;
    bit          clr;
    bit          is_sgn;
    logic [4:0]  is_rd;
    bit          cdb_sgn;
    logic [3:0]  cdb_name;
    logic [31:0] cdb_val;
    logic [3:0]  ord1;
    logic [3:0]  ord2;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          x_full;
    logic [3:0]  x_name;
    bit          x_rdy1;
    logic [31:0] x_val1;
    bit          x_commit;
    logic [4:0]  x_dest;
    logic [31:0] x_value;
  } vec_t;

  // Reference model: instructions in flight, oldest first.
  typedef struct {
    logic [4:0]  rd;
    bit          done;
    logic [31:0] val;
    int          tag;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  bit          x_sgn;
  logic [4:0]  x_dest;
  logic [31:0] x_value;
  logic [3:0]  x_name;
  stim_t       cur;

  function automatic stim_t mk(input bit is_sgn, input logic [4:0] rd, input bit cdb,
                               input logic [3:0] tag, input logic [31:0] v,
                               input logic [3:0] o1);
    stim_t s;
    s.rdy = 1'b1;  s.clr = 1'b0;
    s.is_sgn = is_sgn;  s.is_rd = rd;
    s.cdb_sgn = cdb;  s.cdb_name = tag;  s.cdb_val = v;
    s.ord1 = o1;  s.ord2 = o1 + 4'd1;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tail  = 0;
    x_sgn   = 1'b0;
    x_dest  = '0;
    x_value = '0;
    x_name  = '0;
  endtask

  function automatic void model_lookup(input logic [3:0] tag, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    foreach (mq[i]) begin
      if (mq[i].tag == int'(tag)) begin
        if (mq[i].done) begin
          r = 1'b1;
          v = mq[i].val;
        end
        if (BYP && cur.cdb_sgn && cur.cdb_name == tag) begin
          r = 1'b1;
          v = cur.cdb_val;
        end
      end
    end
  endfunction

  // One clock edge of the model, applied from the current stimulus.
  task automatic model_step();
    bit full;
    bit retire;
    if (!cur.rdy) begin
      x_sgn = 1'b0;
      return;
    end
    if (cur.clr) begin
      mq.delete();
      m_tail = 0;
      x_sgn  = 1'b0;
      return;
    end
    full   = (mq.size() == ROB_DEPTH);
    retire = (mq.size() > 0) && mq[0].done;
    if (retire) begin
      x_sgn   = (mq[0].rd != 5'd0);
      x_dest  = mq[0].rd;
      x_value = mq[0].val;
      x_name  = 4'(mq[0].tag);
    end else begin
      x_sgn = 1'b0;
    end
    if (cur.cdb_sgn) begin
      foreach (mq[i]) begin
        if (mq[i].tag == int'(cur.cdb_name)) begin
          mq[i].done = 1'b1;
          mq[i].val  = cur.cdb_val;
        end
      end
    end
    if (retire) void'(mq.pop_front());
    if (cur.is_sgn && !full) begin
      mq.push_back('{rd: cur.is_rd, done: 1'b0, val: 32'd0, tag: m_tail});
      m_tail = (m_tail + 1) % ROB_DEPTH;
    end
  endtask

  task automatic drive(input stim_t s);
    cur      = s;
    rdy      = s.rdy;
    clr      = s.clr;
    IS_sgn   = s.is_sgn;
    IS_rd    = s.is_rd;
    CDB_sgn  = s.cdb_sgn;
    CDB_name = s.cdb_name;
    CDB_val  = s.cdb_val;
    ROB_ord1 = s.ord1;
    ROB_ord2 = s.ord2;
  endtask

  // Drive inputs mid-cycle and compare the combinational outputs.
  task automatic apply(input stim_t s);
    bit          r;
    logic [31:0] v;
    drive(s);
    #1;
    check("is_full", 32'(IS_full), 32'(mq.size() == ROB_DEPTH));
    check("rob_name", 32'(ROB_name), 32'(m_tail));
    model_lookup(s.ord1, r, v);
    check("rob_rdy1", 32'(ROB_rdy1), 32'(r));
    check("rob_val1", ROB_val1, v);
    model_lookup(s.ord2, r, v);
    check("rob_rdy2", 32'(ROB_rdy2), 32'(r));
    check("rob_val2", ROB_val2, v);
  endtask

  // Advance one edge and compare the registered commit port.
  task automatic clock_edge();
    model_step();
    @(posedge clk);
    #1;
    check("commit_sgn", 32'(ROB_commit_sgn), 32'(x_sgn));
    if (x_sgn) begin
      check("commit_dest", 32'(ROB_commit_dest), 32'(x_dest));
      check("commit_value", ROB_commit_value, x_value);
      check("commit_name", 32'(ROB_commit_ROB_name), 32'(x_name));
    end
  endtask

  task automatic cycle(input stim_t s);
    apply(s);
    clock_edge();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(idle());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_commit_sgn", 32'(ROB_commit_sgn), 32'd0);
    check("rst_commit_value", ROB_commit_value, 32'd0);
    rst = 1'b1;
  endtask

  vec_t  tbl[8];
  stim_t s;

  initial begin
    // Allocate rd 1,2,3; results arrive out of order; retire in order.
    tbl[0] = '{mk(1'b1, 5'd1, 1'b0, 4'd0, 32'h0,  4'd0), 1'b0, 4'd0, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    tbl[1] = '{mk(1'b1, 5'd2, 1'b0, 4'd0, 32'h0,  4'd0), 1'b0, 4'd1, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    tbl[2] = '{mk(1'b1, 5'd3, 1'b0, 4'd0, 32'h0,  4'd0), 1'b0, 4'd2, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    tbl[3] = '{mk(1'b0, 5'd0, 1'b1, 4'd1, 32'hAA, 4'd0), 1'b0, 4'd3, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0};
    tbl[4] = '{mk(1'b0, 5'd0, 1'b1, 4'd0, 32'h55, 4'd1), 1'b0, 4'd3, 1'b1, 32'hAA, 1'b0, 5'd0, 32'h0};
    tbl[5] = '{mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  4'd1), 1'b0, 4'd3, 1'b1, 32'hAA, 1'b1, 5'd1, 32'h55};
    tbl[6] = '{mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  4'd2), 1'b0, 4'd3, 1'b0, 32'h0,  1'b1, 5'd2, 32'hAA};
    tbl[7] = '{mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  4'd0), 1'b0, 4'd3, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].s);
      check($sformatf("tbl%0d_full", i), 32'(IS_full), 32'(tbl[i].x_full));
      check($sformatf("tbl%0d_name", i), 32'(ROB_name), 32'(tbl[i].x_name));
      check($sformatf("tbl%0d_rdy1", i), 32'(ROB_rdy1), 32'(tbl[i].x_rdy1));
      check($sformatf("tbl%0d_val1", i), ROB_val1, tbl[i].x_val1);
      clock_edge();
      check($sformatf("tbl%0d_commit", i), 32'(ROB_commit_sgn), 32'(tbl[i].x_commit));
      if (tbl[i].x_commit) begin
        check($sformatf("tbl%0d_dest", i), 32'(ROB_commit_dest), 32'(tbl[i].x_dest));
        check($sformatf("tbl%0d_value", i), ROB_commit_value, tbl[i].x_value);
      end
    end

    // Fill all entries, try to issue while full, then retire one.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(mk(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 4'd0));
    apply(mk(1'b1, 5'd5, 1'b0, 4'd0, 32'd0, 4'd0));
    check("full_flag", 32'(IS_full), 32'd1);
    check("full_name", 32'(ROB_name), 32'd0);
    clock_edge();
    apply(idle());
    check("full_hold", 32'(IS_full), 32'd1);
    clock_edge();
    cycle(mk(1'b0, 5'd0, 1'b1, 4'd0, 32'hBEEF, 4'd0));
    apply(mk(1'b1, 5'd5, 1'b0, 4'd0, 32'd0, 4'd0));
    check("full_commit_cycle_full", 32'(IS_full), 32'd1);
    clock_edge();
    check("full_commit", 32'(ROB_commit_sgn), 32'd1);
    check("full_commit_value", ROB_commit_value, 32'hBEEF);
    apply(idle());
    check("full_freed", 32'(IS_full), 32'd0);
    check("full_wrap_name", 32'(ROB_name), 32'd0);
    clock_edge();
    cycle(mk(1'b1, 5'd9, 1'b0, 4'd0, 32'd0, 4'd0));
    apply(idle());
    check("refill_full", 32'(IS_full), 32'd1);
    check("refill_name", 32'(ROB_name), 32'd1);
    clock_edge();

    // Lookup after and during a broadcast.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(mk(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 4'd0));
    apply(mk(1'b0, 5'd0, 1'b1, 4'd2, 32'h1234, 4'd2));
    check("bypass_rdy1", 32'(ROB_rdy1), 32'(BYP));
    check("bypass_val1", ROB_val1, BYP ? 32'h1234 : 32'h0);
    clock_edge();
    apply(mk(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd2));
    check("lookup_rdy1", 32'(ROB_rdy1), 32'd1);
    check("lookup_val1", ROB_val1, 32'h1234);
    clock_edge();

    // Flush with simultaneous issue and CDB, then a stale broadcast.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(mk(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 4'd0));
    cycle(mk(1'b0, 5'd0, 1'b1, 4'd1, 32'h77, 4'd0));
    s = mk(1'b1, 5'd6, 1'b1, 4'd0, 32'h99, 4'd0);
    s.clr = 1'b1;
    cycle(s);
    check("clr_commit", 32'(ROB_commit_sgn), 32'd0);
    apply(mk(1'b0, 5'd0, 1'b1, 4'd3, 32'hDEAD, 4'd3));
    check("clr_name", 32'(ROB_name), 32'd0);
    check("clr_full", 32'(IS_full), 32'd0);
    check("stale_rdy1_now", 32'(ROB_rdy1), 32'd0);
    clock_edge();
    apply(mk(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd3));
    check("stale_rdy1_next", 32'(ROB_rdy1), 32'd0);
    clock_edge();
    check("stale_no_commit", 32'(ROB_commit_sgn), 32'd0);

    // rd==0 retires silently, head still advances.
    do_reset();
    cycle(mk(1'b1, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0));
    cycle(mk(1'b1, 5'd7, 1'b0, 4'd0, 32'd0, 4'd0));
    cycle(mk(1'b0, 5'd0, 1'b1, 4'd0, 32'h11, 4'd0));
    cycle(mk(1'b0, 5'd0, 1'b1, 4'd1, 32'h22, 4'd0));
    check("rd0_no_pulse", 32'(ROB_commit_sgn), 32'd0);
    cycle(idle());
    check("rd0_next_pulse", 32'(ROB_commit_sgn), 32'd1);
    check("rd0_next_name", 32'(ROB_commit_ROB_name), 32'd1);
    check("rd0_next_dest", 32'(ROB_commit_dest), 32'd7);

    // rdy low holds state and suppresses the pulse.
    do_reset();
    cycle(mk(1'b1, 5'd3, 1'b0, 4'd0, 32'd0, 4'd0));
    cycle(mk(1'b0, 5'd0, 1'b1, 4'd0, 32'h5A, 4'd0));
    s = idle();
    s.rdy = 1'b0;
    cycle(s);
    check("stall_no_pulse", 32'(ROB_commit_sgn), 32'd0);
    cycle(idle());
    check("stall_then_commit", 32'(ROB_commit_sgn), 32'd1);

    // Asynchronous reset in the middle of a commit pulse.
    do_reset();
    cycle(mk(1'b1, 5'd4, 1'b0, 4'd0, 32'd0, 4'd0));
    cycle(mk(1'b1, 5'd6, 1'b0, 4'd0, 32'd0, 4'd0));
    cycle(mk(1'b0, 5'd0, 1'b1, 4'd0, 32'h321, 4'd0));
    cycle(mk(1'b0, 5'd0, 1'b1, 4'd1, 32'h654, 4'd1));
    check("pre_arst_pulse", 32'(ROB_commit_sgn), 32'd1);
    drive(mk(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd1));
    #2;
    rst = 1'b0;
    #1;
    check("arst_commit_sgn", 32'(ROB_commit_sgn), 32'd0);
    check("arst_commit_dest", 32'(ROB_commit_dest), 32'd0);
    check("arst_commit_value", ROB_commit_value, 32'd0);
    check("arst_commit_name", 32'(ROB_commit_ROB_name), 32'd0);
    check("arst_name", 32'(ROB_name), 32'd0);
    check("arst_rdy1", 32'(ROB_rdy1), 32'd0);
    check("arst_val1", ROB_val1, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic against the queue model.
    for (int i = 0; i < 800; i++) begin
      s = idle();
      s.rdy    = ($urandom_range(0, 9) != 0);
      s.clr    = ($urandom_range(0, 79) == 0);
      s.is_sgn = ((i % 200) < 110) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      s.is_rd  = 5'($urandom_range(0, 31));
      s.cdb_sgn = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
        s.cdb_name = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        s.cdb_name = 4'($urandom_range(0, 15));
      s.cdb_val = $urandom();
      s.ord1    = ($urandom_range(0, 3) == 0) ? s.cdb_name : 4'($urandom_range(0, 15));
      s.ord2    = 4'($urandom_range(0, 15));
      cycle(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
